// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: accepts one burst command and walks it beat by beat,
// producing FIXED/INCR/WRAP addresses plus an error flag for illegal commands.
module axi_burst_addr_gen #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
    output logic [AXI_ID_WIDTH-1:0]   beat_id,
    output logic [AXI_LEN_WIDTH-1:0]  beat_idx,
    output logic                      beat_last,
    output logic                      beat_err
);
    localparam int AW       = AXI_ADDR_WIDTH;
    localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

    typedef enum logic { S_IDLE, S_BURST } state_e;
    typedef enum logic [1:0] { M_FIXED, M_INCR, M_WRAP } mode_e;

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]  id_q, id_d;
    logic [AXI_LEN_WIDTH-1:0] idx_q, idx_d;
    logic [AXI_LEN_WIDTH-1:0] len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic                     last_q, last_d;
    logic                     err_q, err_d;

    // Command decode; an oversized beat is clamped to the bus width.
    logic [2:0]    eff_size;
    logic [AW-1:0] cmd_bytes, cmd_aligned, cmd_end;
    logic          wrap_len_ok, wrap_ok, cross_4k, size_bad, cmd_err;
    mode_e         cmd_mode;

    always_comb begin
        size_bad    = cmd_size > 3'(MAX_SIZE);
        eff_size    = size_bad ? 3'(MAX_SIZE) : cmd_size;
        cmd_bytes   = AW'(1) << eff_size;
        cmd_aligned = cmd_addr & ~(cmd_bytes - AW'(1));
        cmd_end     = cmd_aligned + ((AW'(cmd_len) + AW'(1)) << eff_size) - AW'(1);
        cross_4k    = ((cmd_end ^ cmd_addr) >> 12) != '0;
        wrap_len_ok = (cmd_len == AXI_LEN_WIDTH'(1)) || (cmd_len == AXI_LEN_WIDTH'(3)) ||
                      (cmd_len == AXI_LEN_WIDTH'(7)) || (cmd_len == AXI_LEN_WIDTH'(15));
        wrap_ok     = wrap_len_ok && ((cmd_addr & (cmd_bytes - AW'(1))) == '0);
        cmd_err     = (cmd_burst == 2'd3) || size_bad ||
                      ((cmd_burst == 2'd2) && !wrap_ok) ||
                      ((cmd_burst == 2'd1) && cross_4k);
        if (cmd_burst == 2'd0)                  cmd_mode = M_FIXED;
        else if ((cmd_burst == 2'd2) && wrap_ok) cmd_mode = M_WRAP;
        else                                     cmd_mode = M_INCR;
    end

    // Next beat address: align to the beat size, step one beat, fold back inside the wrap window.
    logic [AW-1:0] bytes, inc, wrap_w, lower, next_addr;

    always_comb begin
        bytes  = AW'(1) << size_q;
        inc    = (addr_q & ~(bytes - AW'(1))) + bytes;
        wrap_w = (AW'(len_q) + AW'(1)) << size_q;
        lower  = addr_q & ~(wrap_w - AW'(1));
        case (mode_q)
            M_FIXED: next_addr = addr_q;
            M_WRAP:  next_addr = (inc == lower + wrap_w) ? lower : inc;
            default: next_addr = inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        id_d    = id_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_BURST;
                    mode_d  = cmd_mode;
                    addr_d  = cmd_addr;
                    id_d    = cmd_id;
                    idx_d   = '0;
                    len_d   = cmd_len;
                    size_d  = eff_size;
                    last_d  = (cmd_len == '0);
                    err_d   = cmd_err;
                end
            end
            default: begin
                if (beat_ready) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d = next_addr;
                        idx_d  = idx_q + AXI_LEN_WIDTH'(1);
                        last_d = (idx_q + AXI_LEN_WIDTH'(1)) == len_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_FIXED;
            addr_q  <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign beat_valid = (state_q == S_BURST);
    assign beat_addr  = addr_q;
    assign beat_id    = id_q;
    assign beat_idx   = idx_q;
    assign beat_last  = last_q;
    assign beat_err   = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen: a burst-level model pushes expected beats,
// a monitor pops and compares on every beat handshake and checks stall stability.
module tb_axi_burst_addr_gen;
    logic        clk, reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        beat_valid, beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_id;
    logic [7:0]  beat_idx;
    logic        beat_last, beat_err;

    axi_burst_addr_gen #(
        .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_LEN_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
        .beat_id(beat_id), .beat_idx(beat_idx), .beat_last(beat_last), .beat_err(beat_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 1;  // 0 random, 1 always ready, 2 toggle

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Burst-level reference: beat addresses from the AXI rules in plain arithmetic.
    function automatic void push_model(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input logic [3:0] id);
        longint a, bytes, aligned, w, lower, last_byte, x;
        int     eb, n;
        bit     wrap_ok, err;
        exp_t   e;
        a         = longint'(addr);
        eb        = (size > 3) ? 3 : int'(size);
        bytes     = longint'(1) << eb;
        n         = int'(len) + 1;
        aligned   = (a / bytes) * bytes;
        wrap_ok   = (len == 1 || len == 3 || len == 7 || len == 15) && (a % bytes == 0);
        last_byte = aligned + longint'(n) * bytes - 1;
        err = (burst == 2'd3) || (size > 3) || (burst == 2'd2 && !wrap_ok) ||
              (burst == 2'd1 && ((last_byte >> 12) != (a >> 12)));
        w     = longint'(n) * bytes;
        lower = (a / w) * w;
        for (int i = 0; i < n; i++) begin
            if (burst == 2'd0)                x = a;
            else if (burst == 2'd2 && wrap_ok) x = lower + ((a - lower) + longint'(i) * bytes) % w;
            else if (i == 0)                  x = a;
            else                              x = (aligned + longint'(i) * bytes) % 64'h1_0000_0000;
            e.addr = 32'(x);
            e.id   = id;
            e.idx  = 8'(i);
            e.last = (i == n - 1);
            e.err  = err;
            q.push_back(e);
        end
    endfunction

    initial begin
        beat_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       beat_ready = ($urandom_range(0, 9) < 7);
                2:       beat_ready = ~beat_ready;
                default: beat_ready = 1'b1;
            endcase
        end
    end

    // Monitor: a handshake happens at the posedge following a negedge with valid && ready.
    initial begin
        bit   stalled, idle_chk;
        exp_t s, e;
        stalled  = 0;
        idle_chk = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled  = 0;
                idle_chk = 0;
            end else begin
                if (idle_chk) begin
                    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
                    chk("idle_beat_valid", 64'(beat_valid), 64'd0);
                    idle_chk = 0;
                end
                if (stalled) begin
                    chk("stall_valid", 64'(beat_valid), 64'd1);
                    chk("stall_addr", 64'(beat_addr), 64'(s.addr));
                    chk("stall_id", 64'(beat_id), 64'(s.id));
                    chk("stall_idx", 64'(beat_idx), 64'(s.idx));
                    chk("stall_last_err", {62'd0, beat_last, beat_err}, {62'd0, s.last, s.err});
                    stalled = 0;
                end
                if (beat_valid) begin
                    if (beat_ready) begin
                        if (q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_beat: got beat addr %0h idx %0d, expected none",
                                     beat_addr, beat_idx);
                        end else begin
                            e = q.pop_front();
                            chk("beat_addr", 64'(beat_addr), 64'(e.addr));
                            chk("beat_id", 64'(beat_id), 64'(e.id));
                            chk("beat_idx", 64'(beat_idx), 64'(e.idx));
                            chk("beat_last", 64'(beat_last), 64'(e.last));
                            chk("beat_err", 64'(beat_err), 64'(e.err));
                            if (e.last) idle_chk = 1;
                        end
                    end else begin
                        stalled = 1;
                        s.addr = beat_addr;
                        s.id   = beat_id;
                        s.idx  = beat_idx;
                        s.last = beat_last;
                        s.err  = beat_err;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] b, input logic [3:0] id);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: got cmd_ready 0, expected 1 within 2000 cycles");
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = sz;
        cmd_burst = b;
        cmd_id    = id;
        @(posedge clk);
        push_model(a, l, sz, b, id);
        #1;
        // junk on the command port while the burst runs must be ignored
        cmd_valid = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_len   = 8'($urandom);
        cmd_size  = 3'($urandom);
        cmd_burst = 2'($urandom);
        cmd_id    = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || !cmd_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_cmd();
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  sz;
        logic [1:0]  b;
        b  = 2'($urandom);
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        l  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'(2 ** $urandom_range(1, 4) - 1);
        case ($urandom_range(0, 2))
            0:       a = $urandom;
            1:       a = {20'($urandom), 12'hF80 + 12'($urandom_range(0, 127))};
            default: a = $urandom & ~32'h7;
        endcase
        issue(a, l, sz, b, 4'($urandom));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        cmd_burst = '0;
        cmd_id    = '0;
        #12;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_beat_fields", {beat_addr, 4'(beat_id), 8'(beat_idx), 2'b0, beat_last, beat_err}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        rdy_mode = 1;
        issue(32'h1000, 8'd3, 3'd3, 2'd1, 4'd1);
        drain();
        issue(32'h1038, 8'd3, 3'd3, 2'd2, 4'd2);
        drain();
        rdy_mode = 2;
        issue(32'h2004, 8'd2, 3'd2, 2'd0, 4'd3);
        drain();
        rdy_mode = 1;
        issue(32'h0FF8, 8'd1, 3'd3, 2'd1, 4'd4);
        issue(32'h1038, 8'd2, 3'd3, 2'd2, 4'd5);
        issue(32'h3003, 8'd1, 3'd2, 2'd1, 4'd6);
        issue(32'h4000, 8'd0, 3'd6, 2'd3, 4'd7);
        drain();

        // reset in the middle of a burst
        issue(32'h5000, 8'd7, 3'd2, 2'd1, 4'd8);
        n = 0;
        @(negedge clk);
        while (!(beat_valid && beat_idx == 8'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_burst_reached_idx2", 64'(beat_idx), 64'd2);
        cmd_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_fields", {beat_addr, 4'(beat_id), 8'(beat_idx), 2'b0, beat_last, beat_err}, 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_no_beats", 64'(beat_valid), 64'd0);
        issue(32'h6010, 8'd3, 3'd2, 2'd1, 4'd9);
        drain();

        rdy_mode = 0;
        repeat (200) rand_cmd();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
